// File: rtl/load_store_unit.sv
// Load/store unit: one request/ready data-memory transaction per Mem_start, with lane
// steering for stores and sign/zero extension for loads. Optional LSU_TIMEOUT_EN adds an abort timer.
module load_store_unit #(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Mem_start,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        Mem_size,
    input  logic              Load_unsigned,
    input  logic [31:0]       ALU_Result,
    input  logic [31:0]       Read_data_2,
    output logic              Busy,
    output logic              Done,
    output logic              Access_err,
    output logic [31:0]       Load_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]  state;
    logic [1:0]  lo;
    logic [1:0]  size;
    logic        uns;
    logic        err;
    logic        bad;
    logic [31:0] wdata_lanes;
    logic [3:0]  be_lanes;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] ext_data;

    wire unused_addr_bits = &{1'b0, ALU_Result[31:ADDR_W+2], TIMEOUT[0]};

    assign Busy       = (state != IDLE);
    assign Done       = (state == RESP);
    assign mem_req    = (state == ACCESS);
    assign Access_err = Done & err;

    assign bad = (Mem_size == 2'b11)
               | ((Mem_size == 2'b01) & ALU_Result[0])
               | ((Mem_size == 2'b10) & (ALU_Result[1:0] != 2'b00))
               | (MemRead & MemWrite);

    // Store lanes are derived from live inputs and captured at accept.
    always_comb begin
        wdata_lanes = Read_data_2;
        be_lanes    = 4'b1111;
        if (MemWrite && !MemRead) begin
            case (Mem_size)
                2'b00: begin
                    wdata_lanes = {4{Read_data_2[7:0]}};
                    be_lanes    = 4'b0001 << ALU_Result[1:0];
                end
                2'b01: begin
                    wdata_lanes = {2{Read_data_2[15:0]}};
                    be_lanes    = ALU_Result[1] ? 4'b1100 : 4'b0011;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (lo)
            2'd0:    byte_lane = mem_rdata[7:0];
            2'd1:    byte_lane = mem_rdata[15:8];
            2'd2:    byte_lane = mem_rdata[23:16];
            default: byte_lane = mem_rdata[31:24];
        endcase
        half_lane = lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size)
            2'b00:   ext_data = {{24{~uns & byte_lane[7]}}, byte_lane};
            2'b01:   ext_data = {{16{~uns & half_lane[15]}}, half_lane};
            default: ext_data = mem_rdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    logic [15:0] cnt;
    wire timed_out = (cnt == 16'(TIMEOUT - 1));
`else
    wire timed_out = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lo        <= 2'b00;
            size      <= 2'b00;
            uns       <= 1'b0;
            err       <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'b0000;
            Load_data <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (Mem_start && (MemRead || MemWrite)) begin
                    lo        <= ALU_Result[1:0];
                    size      <= Mem_size;
                    uns       <= Load_unsigned;
                    mem_we    <= MemWrite & ~MemRead;
                    mem_addr  <= ALU_Result[ADDR_W+1:2];
                    mem_wdata <= wdata_lanes;
                    mem_be    <= be_lanes;
                    err       <= bad;
                    state     <= bad ? RESP : ACCESS;
`ifdef LSU_TIMEOUT_EN
                    cnt       <= '0;
`endif
                end
                ACCESS: begin
                    // A ready in the limit cycle still completes normally.
                    if (mem_ready) begin
                        state <= RESP;
                        if (!mem_we) Load_data <= ext_data;
                    end else if (timed_out) begin
                        state <= RESP;
                        err   <= 1'b1;
                    end
`ifdef LSU_TIMEOUT_EN
                    if (!mem_ready) cnt <= cnt + 16'd1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected responses go to a scoreboard queue at
// Mem_start and are checked when Done fires; lane/handshake signals are checked in place.
module tb_load_store_unit;
    typedef struct packed {
        logic        err;
        logic [31:0] ld;
    } resp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        Mem_start = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, Load_unsigned = 1'b0;
    logic [1:0]  Mem_size = 2'b00;
    logic [31:0] ALU_Result = '0, Read_data_2 = '0;
    logic        Busy, Done, Access_err, mem_req, mem_we;
    logic [31:0] Load_data, mem_wdata;
    logic [13:0] mem_addr;
    logic [3:0]  mem_be;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    int total = 0;
    int bad = 0;
    resp_t sb[$];

    load_store_unit #(.ADDR_W(14), .TIMEOUT(4)) dut (
        .clock(clock), .reset(reset), .Mem_start(Mem_start), .MemRead(MemRead),
        .MemWrite(MemWrite), .Mem_size(Mem_size), .Load_unsigned(Load_unsigned),
        .ALU_Result(ALU_Result), .Read_data_2(Read_data_2), .Busy(Busy), .Done(Done),
        .Access_err(Access_err), .Load_data(Load_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_resp(input string tag);
        resp_t e;
        chk({tag, ".done"}, 32'(Done), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".err"}, 32'(Access_err), 32'(e.err));
            chk({tag, ".ld"}, Load_data, e.ld);
        end
        chk({tag, ".busy_resp"}, 32'(Busy), 32'd1);
        tick();
        chk({tag, ".done_once"}, 32'(Done), 32'd0);
        chk({tag, ".idle"}, 32'(Busy), 32'd0);
    endtask

    // One legal or illegal access; poke re-pulses Mem_start while waiting.
    task automatic xfer(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic us, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int waits, input logic exp_err,
                        input logic [31:0] exp_ld, input logic [31:0] exp_wd,
                        input logic [3:0] exp_be, input logic exp_we, input logic poke);
        resp_t e;
        e.err = exp_err;
        e.ld  = exp_ld;
        sb.push_back(e);
        Mem_start = 1'b1; MemRead = rd; MemWrite = wr; Mem_size = sz;
        Load_unsigned = us; ALU_Result = addr; Read_data_2 = wd;
        tick();
        Mem_start = 1'b0; ALU_Result = 32'hFFFF_FFFF; Read_data_2 = 32'h5555_5555;
        if (exp_err) begin
            chk({tag, ".no_req"}, 32'(mem_req), 32'd0);
        end else begin
            for (int i = 0; i <= waits; i++) begin
                chk({tag, ".req"}, 32'(mem_req), 32'd1);
                chk({tag, ".addr"}, 32'(mem_addr), 32'(addr[15:2]));
                chk({tag, ".be"}, 32'(mem_be), 32'(exp_be));
                chk({tag, ".we"}, 32'(mem_we), 32'(exp_we));
                if (exp_we) chk({tag, ".wdata"}, mem_wdata, exp_wd);
                chk({tag, ".busy"}, 32'(Busy), 32'd1);
                if (i == waits) begin
                    mem_ready = 1'b1;
                    mem_rdata = rdata;
                end else if (poke && i == 1) begin
                    Mem_start = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; ALU_Result = 32'h80;
                end
                tick();
                Mem_start = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
            end
        end
        check_resp(tag);
    endtask

    initial begin
        #2;
        chk("rst.busy", 32'(Busy), 32'd0);
        chk("rst.done", 32'(Done), 32'd0);
        chk("rst.req", 32'(mem_req), 32'd0);
        chk("rst.ld", Load_data, 32'd0);
        chk("rst.be", 32'(mem_be), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        xfer("lw",  1, 0, 2'b10, 0, 32'h10, 0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0, 4'b1111, 0, 0);
        xfer("lb",  1, 0, 2'b00, 0, 32'h13, 0, 32'h80112233, 0, 0, 32'hFFFFFF80, 0, 4'b1111, 0, 0);
        xfer("lbu", 1, 0, 2'b00, 1, 32'h13, 0, 32'h80112233, 0, 0, 32'h00000080, 0, 4'b1111, 0, 0);
        xfer("lh",  1, 0, 2'b01, 0, 32'h12, 0, 32'h80112233, 0, 0, 32'hFFFF8011, 0, 4'b1111, 0, 0);
        xfer("sb",  0, 1, 2'b00, 0, 32'h21, 32'hA5, 0, 0, 0, 32'hFFFF8011, 32'hA5A5A5A5, 4'b0010, 1, 0);
        xfer("sh",  0, 1, 2'b01, 0, 32'h22, 32'h1234, 0, 0, 0, 32'hFFFF8011, 32'h12341234, 4'b1100, 1, 0);
        xfer("sw",  0, 1, 2'b10, 0, 32'h30, 32'hCAFEF00D, 0, 2, 0, 32'hFFFF8011, 32'hCAFEF00D, 4'b1111, 1, 0);
        xfer("wait", 1, 0, 2'b10, 0, 32'h40, 0, 32'h0BADF00D, 5, 0, 32'h0BADF00D, 0, 4'b1111, 0, 1);
        xfer("mis", 1, 0, 2'b10, 0, 32'h42, 0, 0, 0, 1, 32'h0BADF00D, 0, 4'b1111, 0, 0);
        xfer("rdwr", 1, 1, 2'b10, 0, 32'h40, 0, 0, 0, 1, 32'h0BADF00D, 0, 4'b1111, 0, 0);
        xfer("ilsz", 1, 0, 2'b11, 0, 32'h40, 0, 0, 0, 1, 32'h0BADF00D, 0, 4'b1111, 0, 0);
        xfer("hmis", 0, 1, 2'b01, 0, 32'h43, 32'h1, 0, 0, 1, 32'h0BADF00D, 0, 4'b1111, 0, 0);

        // Neither read nor write: the start must be ignored.
        Mem_start = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        tick();
        Mem_start = 1'b0;
        chk("noop.busy", 32'(Busy), 32'd0);
        chk("noop.req", 32'(mem_req), 32'd0);

        // Reset while in ACCESS.
        Mem_start = 1'b1; MemRead = 1'b1; Mem_size = 2'b10; ALU_Result = 32'h44;
        tick();
        Mem_start = 1'b0;
        chk("mrst.req_pre", 32'(mem_req), 32'd1);
        tick();
        reset = 1'b0;
        #1;
        chk("mrst.req", 32'(mem_req), 32'd0);
        chk("mrst.busy", 32'(Busy), 32'd0);
        chk("mrst.done", 32'(Done), 32'd0);
        tick();
        chk("mrst.done2", 32'(Done), 32'd0);
        reset = 1'b1;
        tick();
        xfer("lhu", 1, 0, 2'b01, 1, 32'h2, 0, 32'hABCD0000, 1, 0, 32'h0000ABCD, 0, 4'b1111, 0, 0);

`ifdef LSU_TIMEOUT_EN
        sb.push_back('{err: 1'b1, ld: 32'h0000ABCD});
        Mem_start = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Mem_size = 2'b10; ALU_Result = 32'h50;
        tick();
        Mem_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("tmo.req", 32'(mem_req), 32'd1);
            tick();
        end
        chk("tmo.req_drop", 32'(mem_req), 32'd0);
        check_resp("tmo");
`endif

        chk("sb.drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
